// File: rtl/cascade_stage_scheduler_if.sv
// Bundle between the window scanner, the stage database / tree evaluator datapath and the cascade scheduler.
// master = scheduler side, slave = surrounding datapath and scanner.
interface cascade_stage_scheduler_if #(
  parameter int NUM_STAGES    = 4,
  parameter int DATA_WIDTH_16 = 16,
  parameter int ACC_WIDTH     = 20
);
  logic                            i_start;
  logic                            i_tree_valid;
  logic signed [DATA_WIDTH_16-1:0] i_tree_value;
  logic                            i_end_database;
  logic signed [DATA_WIDTH_16-1:0] i_stage_threshold;

  logic                            o_stage_reset;
  logic [NUM_STAGES-1:0]           o_stage_enable;
  logic [3:0]                      o_stage_index;
  logic signed [ACC_WIDTH-1:0]     o_score;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_face;
  logic                            o_error;

  modport master (
    input  i_start, i_tree_valid, i_tree_value, i_end_database, i_stage_threshold,
    output o_stage_reset, o_stage_enable, o_stage_index, o_score,
    output o_busy, o_done, o_face, o_error
  );

  modport slave (
    output i_start, i_tree_valid, i_tree_value, i_end_database, i_stage_threshold,
    input  o_stage_reset, o_stage_enable, o_stage_index, o_score,
    input  o_busy, o_done, o_face, o_error
  );
endinterface

// File: rtl/cascade_stage_scheduler.sv
// Haar cascade sequencer: per stage CLEAR(1) + RUN(N) + COMPARE(1), verdict pulse one cycle after the last COMPARE.
// No backpressure: votes/end strobes are sampled only in RUN; i_start is dropped unless idle.
module cascade_stage_scheduler #(
  parameter int NUM_STAGES     = 4,
  parameter int DATA_WIDTH_16  = 16,
  parameter int ACC_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                       clk,
  input logic                       reset,
  cascade_stage_scheduler_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_STAGE = 4'(NUM_STAGES - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_COMPARE, S_DONE} state_t;

  state_t                          state;
  logic [TW-1:0]                   timeout_cnt;
  logic signed [DATA_WIDTH_16-1:0] threshold_q;
  logic signed [ACC_WIDTH:0]       sum_wide;
  logic signed [ACC_WIDTH-1:0]     score_next;
  logic signed [ACC_WIDTH-1:0]     threshold_ext;

  // One guard bit is enough: both operands fit in ACC_WIDTH signed bits.
  assign sum_wide      = (ACC_WIDTH+1)'($signed(bus.o_score)) + (ACC_WIDTH+1)'($signed(bus.i_tree_value));
  assign threshold_ext = ACC_WIDTH'($signed(threshold_q));

  always_comb begin
    score_next = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      score_next = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      timeout_cnt        <= '0;
      threshold_q        <= '0;
      bus.o_stage_reset  <= 1'b0;
      bus.o_stage_enable <= '0;
      bus.o_stage_index  <= '0;
      bus.o_score        <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_face         <= 1'b0;
      bus.o_error        <= 1'b0;
    end else begin
      bus.o_stage_reset <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_error       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            state             <= S_CLEAR;
            bus.o_busy        <= 1'b1;
            bus.o_stage_index <= '0;
            bus.o_score       <= '0;
            bus.o_face        <= 1'b0;
            bus.o_stage_reset <= 1'b1;
            timeout_cnt       <= '0;
          end
        end
        S_CLEAR: begin
          state              <= S_RUN;
          bus.o_stage_enable <= NUM_STAGES'(1) << bus.o_stage_index;
        end
        S_RUN: begin
          timeout_cnt <= timeout_cnt + TW'(1);
          if (bus.i_tree_valid)
            bus.o_score <= score_next;
          // A final vote arriving with the end strobe is still summed before COMPARE.
          if (bus.i_end_database) begin
            state              <= S_COMPARE;
            threshold_q        <= bus.i_stage_threshold;
            bus.o_stage_enable <= '0;
          end else if (timeout_cnt == TO_LAST) begin
            state              <= S_DONE;
            bus.o_stage_enable <= '0;
            bus.o_done         <= 1'b1;
            bus.o_error        <= 1'b1;
          end
        end
        S_COMPARE: begin
          if (bus.o_score < threshold_ext) begin
            state      <= S_DONE;
            bus.o_done <= 1'b1;
          end else if (bus.o_stage_index == LAST_STAGE) begin
            state      <= S_DONE;
            bus.o_face <= 1'b1;
            bus.o_done <= 1'b1;
          end else begin
            state             <= S_CLEAR;
            bus.o_stage_index <= bus.o_stage_index + 4'd1;
            bus.o_score       <= '0;
            bus.o_stage_reset <= 1'b1;
            timeout_cnt       <= '0;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_stage_scheduler.sv
// Directed bench for cascade_stage_scheduler; verdicts are queued at start and checked on each o_done.
module tb_cascade_stage_scheduler;
  localparam int NS = 2;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int TO = 1023;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cascade_stage_scheduler_if #(.NUM_STAGES(NS), .DATA_WIDTH_16(DW), .ACC_WIDTH(AW)) bus ();

  cascade_stage_scheduler #(
    .NUM_STAGES(NS), .DATA_WIDTH_16(DW), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       face;
    logic       err;
    logic [3:0] stage;
  } verdict_t;

  verdict_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  logic en1_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic vote(input int v);
    bus.i_tree_valid = 1'b1;
    bus.i_tree_value = DW'(v);
    tick();
    bus.i_tree_valid = 1'b0;
  endtask

  task automatic end_db(input int thr);
    bus.i_end_database    = 1'b1;
    bus.i_stage_threshold = DW'(thr);
    tick();
    bus.i_end_database    = 1'b0;
  endtask

  function automatic logic [31:0] score_u();
    return 32'($unsigned(bus.o_score));
  endfunction

  // Scoreboard: every o_done must match the oldest queued verdict.
  always @(negedge clk) begin
    verdict_t e;
    if (bus.o_stage_enable[1]) en1_seen = 1'b1;
    if (bus.o_done === 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_face",  32'(bus.o_face),        32'(e.face));
        chk("sb_error", 32'(bus.o_error),       32'(e.err));
        chk("sb_stage", 32'(bus.o_stage_index), 32'(e.stage));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start           = 1'b0;
    bus.i_tree_valid      = 1'b0;
    bus.i_tree_value      = '0;
    bus.i_end_database    = 1'b0;
    bus.i_stage_threshold = '0;
    #2 reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy",   32'(bus.o_busy),         32'd0);
    chk("rst_done",   32'(bus.o_done),         32'd0);
    chk("rst_face",   32'(bus.o_face),         32'd0);
    chk("rst_enable", 32'(bus.o_stage_enable), 32'd0);
    chk("rst_score",  score_u(),               32'd0);
    chk("rst_sreset", 32'(bus.o_stage_reset),  32'd0);
    reset = 1'b0;
    tick();

    // Two passing stages: +5 +3 -2 against threshold 6.
    exp_q.push_back('{face: 1'b1, err: 1'b0, stage: 4'd1});
    start();
    chk("t1_clear_pulse", 32'(bus.o_stage_reset),  32'd1);
    chk("t1_busy",        32'(bus.o_busy),         32'd1);
    chk("t1_en_clear",    32'(bus.o_stage_enable), 32'd0);
    tick();
    chk("t1_en_s0", 32'(bus.o_stage_enable), 32'b01);
    vote(5); vote(3); vote(-2);
    chk("t1_score_s0", score_u(), 32'd6);
    end_db(6);
    chk("t1_en_cmp", 32'(bus.o_stage_enable), 32'd0);
    tick();
    chk("t1_idx1",      32'(bus.o_stage_index), 32'd1);
    chk("t1_score_clr", score_u(),              32'd0);
    chk("t1_sreset1",   32'(bus.o_stage_reset), 32'd1);
    tick();
    chk("t1_en_s1", 32'(bus.o_stage_enable), 32'b10);
    vote(5); vote(3); vote(-2);
    end_db(6);
    tick();
    chk("t1_done", 32'(bus.o_done), 32'd1);
    tick();
    chk("t1_busy_fall", 32'(bus.o_busy),        32'd0);
    chk("t1_face_hold", 32'(bus.o_face),        32'd1);
    chk("t1_idx_hold",  32'(bus.o_stage_index), 32'd1);
    chk("t1_done_pulse", 32'(bus.o_done),       32'd0);

    // Stage 0 fails; a vote during CLEAR must be ignored.
    exp_q.push_back('{face: 1'b0, err: 1'b0, stage: 4'd0});
    en1_seen = 1'b0;
    start();
    vote(100);
    chk("t2_en_s0", 32'(bus.o_stage_enable), 32'b01);
    vote(1); vote(1);
    chk("t2_score", score_u(), 32'd2);
    end_db(5);
    tick();
    chk("t2_done", 32'(bus.o_done), 32'd1);
    tick();
    chk("t2_busy", 32'(bus.o_busy), 32'd0);
    chk("t2_no_en1", 32'(en1_seen), 32'd0);

    // Saturation at both rails.
    exp_q.push_back('{face: 1'b0, err: 1'b0, stage: 4'd0});
    start();
    tick();
    repeat (16) vote(32767);
    chk("t3_below_max", score_u(), 32'h7FFF0);
    vote(32767);
    chk("t3_clamp_max", score_u(), 32'h7FFFF);
    repeat (23) vote(32767);
    chk("t3_hold_max", score_u(), 32'h7FFFF);
    vote(-32768);
    chk("t3_off_max", score_u(), 32'h77FFF);
    repeat (39) vote(-32768);
    chk("t3_clamp_min", score_u(), 32'h80000);
    end_db(0);
    tick();
    tick();

    // Timeout: RUN lasts exactly TO cycles without an end strobe.
    exp_q.push_back('{face: 1'b0, err: 1'b1, stage: 4'd0});
    start();
    tick();
    repeat (TO - 1) tick();
    chk("t4_not_yet", 32'(bus.o_done),         32'd0);
    chk("t4_en_run",  32'(bus.o_stage_enable), 32'b01);
    tick();
    chk("t4_done",  32'(bus.o_done),  32'd1);
    chk("t4_error", 32'(bus.o_error), 32'd1);
    chk("t4_face",  32'(bus.o_face),  32'd0);
    tick();
    chk("t4_err_pulse", 32'(bus.o_error), 32'd0);
    chk("t4_busy",      32'(bus.o_busy),  32'd0);

    // Spurious start in RUN is ignored.
    exp_q.push_back('{face: 1'b1, err: 1'b0, stage: 4'd1});
    start();
    tick();
    vote(5); vote(3);
    bus.i_start = 1'b1;
    vote(-2);
    bus.i_start = 1'b0;
    chk("t5_idx_kept", 32'(bus.o_stage_index), 32'd0);
    chk("t5_score",    score_u(),              32'd6);
    end_db(6);
    tick();
    tick();
    vote(5); vote(3); vote(-2);
    end_db(6);
    tick();
    tick();
    chk("t5_face", 32'(bus.o_face), 32'd1);

    // Async reset during stage 1: outputs clear at once, no verdict.
    start();
    tick();
    vote(6);
    end_db(6);
    tick();
    tick();
    vote(5);
    chk("t6_en_s1", 32'(bus.o_stage_enable), 32'b10);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy",   32'(bus.o_busy),         32'd0);
    chk("t6_enable", 32'(bus.o_stage_enable), 32'd0);
    chk("t6_score",  score_u(),               32'd0);
    chk("t6_idx",    32'(bus.o_stage_index),  32'd0);
    chk("t6_face",   32'(bus.o_face),         32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Fresh pass after reset; score equal to threshold with a coincident last vote.
    exp_q.push_back('{face: 1'b1, err: 1'b0, stage: 4'd1});
    start();
    tick();
    vote(4);
    bus.i_tree_valid = 1'b1;
    bus.i_tree_value = DW'(2);
    end_db(6);
    bus.i_tree_valid = 1'b0;
    chk("t7_coincident", score_u(), 32'd6);
    tick();
    tick();
    vote(4);
    bus.i_tree_valid = 1'b1;
    bus.i_tree_value = DW'(2);
    end_db(6);
    bus.i_tree_valid = 1'b0;
    tick();
    chk("t7_done", 32'(bus.o_done), 32'd1);
    tick();
    chk("t7_face", 32'(bus.o_face), 32'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
